// File: rtl/fetch_pc.sv
// Fetch-stage PC unit for the Y86 pipeline: computes valP, predicts the next
// PC (jumps and calls taken) and tracks run / return-wait / halt state.
module fetch_pc #(
  parameter int unsigned          DATA_WID = 64,
  parameter logic [DATA_WID-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          icode,
  input  logic [3:0]          ifun,
  input  logic [DATA_WID-1:0] valC,
  input  logic                stall,
  input  logic                mispredict,
  input  logic [DATA_WID-1:0] mispredict_pc,
  input  logic                ret_valid,
  input  logic [DATA_WID-1:0] ret_pc,
  output logic [DATA_WID-1:0] pc,
  output logic [DATA_WID-1:0] valP,
  output logic                instr_valid,
  output logic                ins_err,
  output logic                halted,
  output logic                ret_wait,
  output logic [31:0]         fetch_cnt
);

  localparam int unsigned LEN_W = 4;
  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_RET_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_WID-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [LEN_W-1:0]    ilen;
  logic                is_jump;
  logic                is_stop;
  logic                is_ret;
  logic [DATA_WID-1:0] pred_pc;

  // Function code does not influence PC generation.
  logic unused_ifun;
  assign unused_ifun = ^ifun;

  // Instruction length decode; invalid codes count as one byte.
  always_comb begin
    ilen = LEN_W'(1);
    case (icode)
      4'h0, 4'h1, 4'h9:       ilen = LEN_W'(1);
      4'h2, 4'h6, 4'hA, 4'hB: ilen = LEN_W'(2);
      4'h3, 4'h4, 4'h5:       ilen = LEN_W'(10);
      4'h7, 4'h8:             ilen = LEN_W'(9);
      default:                ilen = LEN_W'(1);
    endcase
  end

  assign ins_err     = (icode > 4'hB);
  assign is_jump     = (icode == 4'h7) || (icode == 4'h8);
  assign is_ret      = (icode == 4'h9);
  assign is_stop     = (icode == 4'h0) || ins_err;
  assign valP        = pc_q + DATA_WID'(ilen);
  assign pred_pc     = is_jump ? valC : valP;
  assign instr_valid = (state_q == ST_RUN) && !stall && !mispredict;

  // Next-state / next-PC selection: redirect, return, stall, then prediction.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q + CNT_W'(instr_valid);
    if (mispredict) begin
      pc_d    = mispredict_pc;
      state_d = ST_RUN;
    end else if ((state_q == ST_RET_WAIT) && ret_valid) begin
      pc_d    = ret_pc;
      state_d = ST_RUN;
    end else if (!stall && (state_q == ST_RUN)) begin
      if (is_ret) begin
        state_d = ST_RET_WAIT;
      end else if (is_stop) begin
        state_d = ST_HALT;
      end else begin
        pc_d = pred_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc        = pc_q;
  assign fetch_cnt = cnt_q;
  assign halted    = (state_q == ST_HALT);
  assign ret_wait  = (state_q == ST_RET_WAIT);

endmodule

// File: tb/tb_fetch_pc.sv
// Self-checking bench for fetch_pc: directed scenarios followed by randomized
// traffic, both checked against a behavioural model of the fetch PC rules.
module tb_fetch_pc;

  localparam int unsigned W = 64;
  localparam int M_RUN  = 0;
  localparam int M_RETW = 1;
  localparam int M_HALT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    icode, ifun;
  logic [W-1:0]  valC, mispredict_pc, ret_pc;
  logic          stall, mispredict, ret_valid;
  logic [W-1:0]  pc, valP;
  logic          instr_valid, ins_err, halted, ret_wait;
  logic [31:0]   fetch_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [W-1:0]  m_pc;
  int            m_mode;
  logic [31:0]   m_cnt;
  int unsigned   len_tab [0:15] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};

  fetch_pc #(.DATA_WID(W), .RESET_PC('0)) dut (
    .clk(clk), .rst_n(rst_n), .icode(icode), .ifun(ifun), .valC(valC),
    .stall(stall), .mispredict(mispredict), .mispredict_pc(mispredict_pc),
    .ret_valid(ret_valid), .ret_pc(ret_pc), .pc(pc), .valP(valP),
    .instr_valid(instr_valid), .ins_err(ins_err), .halted(halted),
    .ret_wait(ret_wait), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = '0;
    m_mode = M_RUN;
    m_cnt  = '0;
  endtask

  // One clock: drive at negedge, check outputs, advance model across posedge.
  task automatic cyc(input logic [3:0] ic, input logic [W-1:0] vc, input logic st,
                     input logic mp, input logic [W-1:0] mpc,
                     input logic rv, input logic [W-1:0] rpc);
    logic [W-1:0] e_valp;
    logic         e_iv, e_err;
    @(negedge clk);
    icode = ic; ifun = 4'($urandom_range(0, 15)); valC = vc; stall = st;
    mispredict = mp; mispredict_pc = mpc; ret_valid = rv; ret_pc = rpc;
    #1;
    e_valp = m_pc + W'(len_tab[ic]);
    e_err  = (int'(ic) > 11);
    e_iv   = (m_mode == M_RUN) && !st && !mp;
    check_eq("pc",          pc,          m_pc);
    check_eq("halted",      W'(halted),  W'(m_mode == M_HALT));
    check_eq("ret_wait",    W'(ret_wait), W'(m_mode == M_RETW));
    check_eq("fetch_cnt",   W'(fetch_cnt), W'(m_cnt));
    check_eq("valP",        valP,        e_valp);
    check_eq("ins_err",     W'(ins_err), W'(e_err));
    check_eq("instr_valid", W'(instr_valid), W'(e_iv));
    if (e_iv) m_cnt = m_cnt + 32'd1;
    if (mp) begin
      m_pc = mpc; m_mode = M_RUN;
    end else if (m_mode == M_RETW && rv) begin
      m_pc = rpc; m_mode = M_RUN;
    end else if (!st && m_mode == M_RUN) begin
      if (ic == 4'h9)                 m_mode = M_RETW;
      else if (ic == 4'h0 || e_err)   m_mode = M_HALT;
      else if (ic == 4'h7 || ic == 4'h8) m_pc = vc;
      else                            m_pc = e_valp;
    end
    @(posedge clk);
  endtask

  task automatic go(input logic [3:0] ic, input logic [W-1:0] vc);
    cyc(ic, vc, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic redirect(input logic [W-1:0] target);
    cyc(4'h1, '0, 1'b0, 1'b1, target, 1'b0, '0);
  endtask

  initial begin
    logic [W-1:0] big;
    rst_n = 1'b0; icode = 4'h1; ifun = '0; valC = '0; stall = 1'b1;
    mispredict = 1'b0; mispredict_pc = '0; ret_valid = 1'b0; ret_pc = '0;
    model_reset();
    #3;
    check_eq("rst_pc", pc, '0);
    check_eq("rst_halted", W'(halted), '0);
    check_eq("rst_cnt", W'(fetch_cnt), '0);
    @(negedge clk); rst_n = 1'b1;

    // Sequential flow
    go(4'h6, '0); go(4'h3, '0); go(4'h1, '0);
    #1; check_eq("seq_pc", pc, W'(64'hD)); check_eq("seq_cnt", W'(fetch_cnt), W'(3));

    // Jump predicted taken, then mispredict overriding stall
    redirect(W'(64'h10));
    go(4'h7, W'(64'h40));
    #1; check_eq("jmp_pc", pc, W'(64'h40));
    cyc(4'h1, '0, 1'b1, 1'b1, W'(64'h19), 1'b0, '0);
    #1; check_eq("mp_pc", pc, W'(64'h19));

    // Return wait and resolution
    redirect(W'(64'h20));
    go(4'h9, '0);
    for (int i = 0; i < 3; i++) go(4'h9, '0);
    #1; check_eq("retw_pc", pc, W'(64'h20));
    cyc(4'h1, '0, 1'b0, 1'b0, '0, 1'b1, W'(64'h100));
    #1; check_eq("ret_pc", pc, W'(64'h100));

    // Halt ignores ret_valid, recovers on mispredict
    redirect(W'(64'h30));
    go(4'h0, '0);
    for (int i = 0; i < 5; i++) cyc(4'h1, '0, 1'b0, 1'b0, '0, 1'b1, W'(64'h77));
    #1; check_eq("halt_pc", pc, W'(64'h30)); check_eq("halt_flag", W'(halted), W'(1));
    redirect(W'(64'h50));
    #1; check_eq("unhalt_pc", pc, W'(64'h50));

    // Invalid instruction, then PC wrap
    go(4'hD, '0);
    #1; check_eq("inv_halt", W'(halted), W'(1));
    redirect(~W'(0));
    go(4'h1, '0);
    #1; check_eq("wrap_pc", pc, '0);

    // Reset from RET_WAIT mid-cycle
    redirect(W'(64'h60));
    go(4'h9, '0);
    @(negedge clk); #2; stall = 1'b1; rst_n = 1'b0; #1;
    model_reset();
    check_eq("mrst_pc", pc, '0);
    check_eq("mrst_retw", W'(ret_wait), '0);
    check_eq("mrst_cnt", W'(fetch_cnt), '0);
    @(negedge clk); rst_n = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [3:0] ic;
      logic st, mp, rv;
      r = int'($urandom_range(0, 99));
      if (r < 4)      ic = 4'h0;
      else if (r < 7) ic = 4'($urandom_range(12, 15));
      else            ic = 4'($urandom_range(1, 11));
      st = ($urandom_range(0, 99) < 15);
      mp = ($urandom_range(0, 99) < ((m_mode == M_HALT) ? 40 : 8));
      rv = ($urandom_range(0, 99) < ((m_mode == M_RETW) ? 40 : 10));
      big = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) big = ~W'(0) - W'($urandom_range(0, 12));
      cyc(ic, {$urandom, $urandom}, st, mp, big, rv, {$urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_pc.md
# fetch_pc

Fetch-stage program-counter unit for the Y86 pipeline. Sits directly upstream of the instruction memory: it drives `pc` into the memory and receives the fetched `icode/ifun/valC` back in the same cycle. From these it computes `valP` and predicts the next PC. It also tracks run/halt/return-wait state and applies branch-misprediction and `ret` corrections fed back from later stages.

## Interface
Parameters:
- `DATA_WID`, 64: address/data width.
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `icode`  in  4  fetched instruction code for the current `pc`.
- `ifun`  in  4  fetched function code (passed through, unused for PC).
- `valC`  in  DATA_WID  fetched constant word.
- `stall`  in  1  hold PC; no instruction issued this cycle.
- `mispredict`  in  1  taken-prediction was wrong; redirect.
- `mispredict_pc`  in  DATA_WID  correct PC on mispredict.
- `ret_valid`  in  1  return address resolved.
- `ret_pc`  in  DATA_WID  resolved return address.
- `pc`  out  DATA_WID  registered current PC, to instruction memory.
- `valP`  out  DATA_WID  `pc` + instruction length (combinational).
- `instr_valid`  out  1  current fetch is issued downstream this cycle.
- `ins_err`  out  1  `icode` > 0xB (combinational).
- `halted`  out  1  state == HALT.
- `ret_wait`  out  1  state == RET_WAIT.
- `fetch_cnt`  out  32  count of issued instructions.

## Operation
Instruction lengths by `icode`:
- 0 halt, 1 nop, 9 ret: 1 byte.
- 2 rrmov/cmov, 6 OPq, A push, B pop: 2 bytes.
- 3 irmovq, 4 rmmovq, 5 mrmovq: 10 bytes.
- 7 jXX, 8 call: 9 bytes.
- Invalid (>0xB): 1 byte.
- `valP` = `pc` + length, modulo 2^DATA_WID. Wrap-around is silent.

Predicted PC:
- `valC` for `icode` 7 or 8 (all jumps predicted taken).
- `valP` otherwise.

States:
- **RUN**
  - `icode` 9 issued → RET_WAIT.
  - `icode` 0 or invalid issued → HALT.
- **RET_WAIT**
  - `ret_valid` → RUN.
- **HALT**
  - `mispredict` → RUN. A halt fetched on a wrong path must be recoverable.

`instr_valid` = (state == RUN) & !stall & !mispredict.
- halt and invalid instructions are issued with `instr_valid` = 1 so their status propagates downstream.

Next-PC priority, evaluated at each rising edge, highest first:
1. `mispredict` (any state): `pc` ← `mispredict_pc`, state ← RUN.
2. `ret_valid` in RET_WAIT: `pc` ← `ret_pc`, state ← RUN. Ignored in RUN and HALT.
3. `stall`: `pc` and state hold.
4. RUN:
   - `icode` 9: `pc` holds.
   - `icode` 0 or invalid: `pc` holds.
   - otherwise: `pc` ← predicted PC.
5. RET_WAIT or HALT: hold.

`fetch_cnt`:
- Increments by 1 on each edge where `instr_valid` = 1.
- Wraps 0xFFFFFFFF → 0.

## Timing
- Reset (asynchronous, on `rst_n` low):
  - `pc` = `RESET_PC`, state = RUN, `fetch_cnt` = 0.
  - `halted` = 0, `ret_wait` = 0.
  - `instr_valid` = !stall & !mispredict.
- `pc`, state and `fetch_cnt` are registered. All other outputs are combinational from registers and inputs.
- Next-PC latency is 1 cycle: an instruction issued at edge N has its successor on `pc` after edge N.
- `mispredict` and `ret_valid` take effect at the next edge. In that same cycle they override `stall`.
- Simultaneous `mispredict` + `ret_valid`: `mispredict` wins. RET_WAIT is left and `ret_pc` is dropped.
- Reset asserted mid-RET_WAIT or mid-HALT returns immediately to RUN at `RESET_PC`.
- `rst_n` deassertion is synchronized externally. The first update occurs on the first edge with `rst_n` high.

## Test plan
1. **Reset:** `RESET_PC` = 0, `rst_n` low mid-cycle → `pc` = 0, `halted` = 0, `ret_wait` = 0, `fetch_cnt` = 0 without waiting for a clock edge.
2. **Sequential flow:**
   - `icode` 6 at `pc` 0 → `valP` = 2; next `pc` = 2.
   - `icode` 3 → next `pc` = 0xC.
   - `icode` 1 → next `pc` = 0xD.
   - `fetch_cnt` = 3.
3. **Jump prediction and recovery:**
   - `icode` 7, `valC` = 0x40 at `pc` 0x10 → `valP` = 0x19; next `pc` = 0x40.
   - Then `mispredict` = 1, `mispredict_pc` = 0x19 with `stall` = 1 → `pc` = 0x19, `instr_valid` = 0 that cycle.
4. **Return:**
   - `icode` 9 at `pc` 0x20 → `ret_wait` = 1; `pc` stays 0x20; `instr_valid` = 0 for 3 cycles; `fetch_cnt` unchanged.
   - Then `ret_valid`, `ret_pc` = 0x100 → `pc` = 0x100, `ret_wait` = 0.
5. **Halt:**
   - `icode` 0 at `pc` 0x30 → `halted` = 1; `pc` holds 0x30 across 5 cycles; `ret_valid` ignored.
   - Then `mispredict_pc` = 0x50 with `mispredict` → `halted` = 0, `pc` = 0x50.
6. **Edge cases:**
   - `icode` 0xD → `ins_err` = 1, `instr_valid` = 1, then `halted` = 1.
   - `pc` = 2^64−1 with `icode` 1 → next `pc` = 0.
